// File: rtl/segre_mem_stage.sv
// Memory stage of the Segre pipeline: latches EX results, runs the data-memory
// request/ack handshake and produces the writeback triple and hazard signals.
module segre_mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_SIZE  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  logic [1:0]           memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
  input  logic                 is_jaljalr_i,
  input  logic                 valid_ex_i,
  input  logic                 finish_test_i,
  input  logic                 block_mem_i,
  input  logic                 inject_nops_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_SIZE-1:0] dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [WORD_SIZE-1:0] dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_data_o,
  output logic                 valid_mem_o,
  output logic                 mem_busy_o,
  output logic                 data_produced_mem_o,
  output logic                 misaligned_o,
  output logic                 finish_test_o
);

  // memop_data_type_e encoding
  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e state_q, state_d;

  logic [WORD_SIZE-1:0] alu_res_q;
  logic                 rf_we_q;
  logic [REG_SIZE-1:0]  rf_waddr_q;
  logic [WORD_SIZE-1:0] st_data_q;
  logic [1:0]           type_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 sext_q;
  logic [ADDR_SIZE-1:0] seq_pc_q;
  logic                 jal_q;
  logic                 valid_q;
  logic                 finish_q;
  logic [WORD_SIZE-1:0] rdata_q;

  logic                 advance;
  logic                 mis_q;
  logic                 in_pend;
  logic [7:0]           lane8;
  logic [15:0]          lane16;
  logic [WORD_SIZE-1:0] load_ext;
  logic [3:0]           be_lanes;
  logic [WORD_SIZE-1:0] wdata_lanes;

  function automatic logic is_mis(input logic [1:0] t, input logic [1:0] a);
    return (t == HALF && a[0]) || (t == WORD && a != 2'b00);
  endfunction

  // A started request always completes, so the latch is frozen while in REQ.
  assign advance = !block_mem_i && state_q != REQ;
  assign mis_q   = is_mis(type_q, alu_res_q[1:0]);
  assign in_pend = !inject_nops_i && valid_ex_i && (memop_rd_i || memop_wr_i) &&
                   !is_mis(memop_type_i, alu_res_i[1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_res_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      st_data_q  <= '0;
      type_q     <= BYTE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      sext_q     <= 1'b0;
      seq_pc_q   <= '0;
      jal_q      <= 1'b0;
      valid_q    <= 1'b0;
      finish_q   <= 1'b0;
    end else if (advance) begin
      if (inject_nops_i) begin
        alu_res_q  <= '0;
        rf_we_q    <= 1'b0;
        rf_waddr_q <= '0;
        st_data_q  <= '0;
        type_q     <= BYTE;
        rd_q       <= 1'b0;
        wr_q       <= 1'b0;
        sext_q     <= 1'b0;
        seq_pc_q   <= '0;
        jal_q      <= 1'b0;
        valid_q    <= 1'b0;
        finish_q   <= 1'b0;
      end else begin
        alu_res_q  <= alu_res_i;
        rf_we_q    <= rf_we_i;
        rf_waddr_q <= rf_waddr_i;
        st_data_q  <= rf_st_data_i;
        type_q     <= memop_type_i;
        rd_q       <= memop_rd_i;
        wr_q       <= memop_wr_i;
        sext_q     <= memop_sign_ext_i;
        seq_pc_q   <= seq_new_pc_i;
        jal_q      <= is_jaljalr_i;
        valid_q    <= valid_ex_i;
        finish_q   <= finish_test_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (state_q == REQ && dmem_ack_i) begin
      rdata_q <= load_ext;
    end
  end

  always_comb begin
    lane8    = 8'h00;
    lane16   = alu_res_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_ext = dmem_rdata_i;
    case (alu_res_q[1:0])
      2'd0: lane8 = dmem_rdata_i[7:0];
      2'd1: lane8 = dmem_rdata_i[15:8];
      2'd2: lane8 = dmem_rdata_i[23:16];
      2'd3: lane8 = dmem_rdata_i[31:24];
      default: lane8 = 8'h00;
    endcase
    case (type_q)
      BYTE:    load_ext = {{24{sext_q & lane8[7]}}, lane8};
      HALF:    load_ext = {{16{sext_q & lane16[15]}}, lane16};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    be_lanes    = 4'hF;
    wdata_lanes = st_data_q;
    case (type_q)
      BYTE: begin
        be_lanes    = 4'b0001 << alu_res_q[1:0];
        wdata_lanes = {4{st_data_q[7:0]}};
      end
      HALF: begin
        be_lanes    = alu_res_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{st_data_q[15:0]}};
      end
      default: begin
        be_lanes    = 4'hF;
        wdata_lanes = st_data_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE behaves like IDLE except it remembers a completed access while blocked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (dmem_ack_i) state_d = DONE;
      end
      IDLE, DONE: begin
        if (advance) state_d = in_pend ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o          = (state_q == REQ);
    mem_busy_o          = (state_q == REQ);
    dmem_we_o           = (state_q == REQ) && wr_q;
    dmem_addr_o         = '0;
    dmem_be_o           = 4'h0;
    dmem_wdata_o        = '0;
    if (state_q == REQ) begin
      dmem_addr_o  = {alu_res_q[ADDR_SIZE-1:2], 2'b00};
      dmem_be_o    = be_lanes;
      dmem_wdata_o = wdata_lanes;
    end
    valid_mem_o         = valid_q && (state_q != REQ);
    rf_we_o             = rf_we_q && valid_q && (state_q != REQ) && !mis_q;
    data_produced_mem_o = rf_we_o;
    misaligned_o        = valid_q && (rd_q || wr_q) && mis_q;
    rf_waddr_o          = rf_waddr_q;
    rf_data_o           = rd_q ? rdata_q : (jal_q ? seq_pc_q : alu_res_q);
    finish_test_o       = finish_q;
  end

endmodule
